// File: rtl/tcm_mem.sv
// tcm_mem: byte-addressed tightly-coupled memory with two 16-byte read
// windows (fetch, store buffer) and one 1/2/4-byte write port.
// Storage is split into 16 byte-wide banks selected by addr[3:0], so any
// unaligned 16-byte window or 4-byte write touches each bank at most once.
// Reads are write-first: a write landing at the same edge is bypassed into
// the read window.
module tcm_mem #(
  parameter int ADDR_WIDTH     = 32,
  parameter int BUS_DATA_WIDTH = 128,
  parameter int REG_DATA_WIDTH = 32,
  parameter int SIZE_WIDTH     = 3,
  parameter int TCM_SIZE       = 16384
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     bus_tcm_fetch_addr,
  input  logic                      bus_tcm_fetch_rd,
  output logic [BUS_DATA_WIDTH-1:0] tcm_bus_fetch_data,
  input  logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_read_addr,
  input  logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_read_size,
  input  logic                      bus_tcm_stbuf_rd,
  output logic [BUS_DATA_WIDTH-1:0] tcm_bus_stbuf_data,
  input  logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_write_addr,
  input  logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_write_size,
  input  logic [REG_DATA_WIDTH-1:0] bus_tcm_stbuf_data,
  input  logic                      bus_tcm_stbuf_wr
);

  localparam int NBANK = BUS_DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(TCM_SIZE);
  localparam int ROW_W = IDX_W - 4;
  localparam int ROWS  = TCM_SIZE / NBANK;
  localparam int NPORT = 2;

  logic [7:0] bank_mem [NBANK][ROWS];

  logic [IDX_W-1:0] wr_addr;
  logic [2:0]       wr_len;
  logic [NBANK-1:0] wr_bank_en;
  logic [ROW_W-1:0] wr_row  [NBANK];
  logic [7:0]       wr_byte [NBANK];

  logic [IDX_W-1:0]          rd_addr [NPORT];
  logic [7:0]                rd_bank [NPORT][NBANK];
  logic [BUS_DATA_WIDTH-1:0] rd_win  [NPORT];

  logic [BUS_DATA_WIDTH-1:0] fetch_data_q;
  logic [BUS_DATA_WIDTH-1:0] stbuf_data_q;

  // Read size is informational only and upper address bits alias the array.
  logic unused_bits;
  assign unused_bits = ^{bus_tcm_stbuf_read_size,
                         bus_tcm_fetch_addr[ADDR_WIDTH-1:IDX_W],
                         bus_tcm_stbuf_read_addr[ADDR_WIDTH-1:IDX_W],
                         bus_tcm_stbuf_write_addr[ADDR_WIDTH-1:IDX_W]};

  assign wr_addr    = bus_tcm_stbuf_write_addr[IDX_W-1:0];
  assign rd_addr[0] = bus_tcm_fetch_addr[IDX_W-1:0];
  assign rd_addr[1] = bus_tcm_stbuf_read_addr[IDX_W-1:0];

  // Effective write length: sizes above 4 saturate to a full word.
  always_comb begin
    wr_len = 3'd0;
    if (bus_tcm_stbuf_write_size > SIZE_WIDTH'(4)) begin
      wr_len = 3'd4;
    end else begin
      wr_len = 3'(bus_tcm_stbuf_write_size);
    end
  end

  // Per-bank write decode: which data byte lands in each bank and on which row.
  // Banks below the start offset belong to the next line (row + 1).
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      logic [3:0]                off;
      logic [REG_DATA_WIDTH-1:0] sh;
      off           = 4'(b) - wr_addr[3:0];
      sh            = bus_tcm_stbuf_data >> {off[1:0], 3'b000};
      wr_byte[b]    = sh[7:0];
      wr_bank_en[b] = bus_tcm_stbuf_wr && ({1'b0, off} < {2'b00, wr_len});
      wr_row[b]     = wr_addr[IDX_W-1:4] + ROW_W'(4'(b) < wr_addr[3:0]);
    end
  end

  // Bank storage update; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NBANK; b++) begin
      if (wr_bank_en[b]) begin
        bank_mem[b][wr_row[b]] <= wr_byte[b];
      end
    end
  end

  // Per-port bank lookup with write-first bypass, then rotate so window
  // byte 0 is the byte at the requested address.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      rd_win[p] = '0;
      for (int b = 0; b < NBANK; b++) begin
        logic [ROW_W-1:0] row;
        row = rd_addr[p][IDX_W-1:4] + ROW_W'(4'(b) < rd_addr[p][3:0]);
        rd_bank[p][b] = bank_mem[b][row];
        if (wr_bank_en[b] && (wr_row[b] == row)) begin
          rd_bank[p][b] = wr_byte[b];
        end
      end
      for (int i = 0; i < NBANK; i++) begin
        logic [3:0] sel;
        sel = rd_addr[p][3:0] + 4'(i);
        rd_win[p][8*i +: 8] = rd_bank[p][sel];
      end
    end
  end

  // Fetch window register; holds when not reading.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_data_q <= '0;
    end else if (bus_tcm_fetch_rd) begin
      fetch_data_q <= rd_win[0];
    end
  end

  // Store-buffer window register; holds when not reading.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stbuf_data_q <= '0;
    end else if (bus_tcm_stbuf_rd) begin
      stbuf_data_q <= rd_win[1];
    end
  end

  assign tcm_bus_fetch_data = fetch_data_q;
  assign tcm_bus_stbuf_data = stbuf_data_q;

endmodule

// File: tb/tb_tcm_mem.sv
// Testbench for tcm_mem: stimulus pushes expected windows into per-port
// queues, a monitor pops and compares one cycle after each sampled read.
module tb_tcm_mem;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  bus_tcm_fetch_addr;
  logic         bus_tcm_fetch_rd;
  logic [127:0] tcm_bus_fetch_data;
  logic [31:0]  bus_tcm_stbuf_read_addr;
  logic [2:0]   bus_tcm_stbuf_read_size;
  logic         bus_tcm_stbuf_rd;
  logic [127:0] tcm_bus_stbuf_data;
  logic [31:0]  bus_tcm_stbuf_write_addr;
  logic [2:0]   bus_tcm_stbuf_write_size;
  logic [31:0]  bus_tcm_stbuf_data;
  logic         bus_tcm_stbuf_wr;

  always #5 clk = ~clk;

  tcm_mem dut (
    .clk                      (clk),
    .rst                      (rst),
    .bus_tcm_fetch_addr       (bus_tcm_fetch_addr),
    .bus_tcm_fetch_rd         (bus_tcm_fetch_rd),
    .tcm_bus_fetch_data       (tcm_bus_fetch_data),
    .bus_tcm_stbuf_read_addr  (bus_tcm_stbuf_read_addr),
    .bus_tcm_stbuf_read_size  (bus_tcm_stbuf_read_size),
    .bus_tcm_stbuf_rd         (bus_tcm_stbuf_rd),
    .tcm_bus_stbuf_data       (tcm_bus_stbuf_data),
    .bus_tcm_stbuf_write_addr (bus_tcm_stbuf_write_addr),
    .bus_tcm_stbuf_write_size (bus_tcm_stbuf_write_size),
    .bus_tcm_stbuf_data       (bus_tcm_stbuf_data),
    .bus_tcm_stbuf_wr         (bus_tcm_stbuf_wr)
  );

  typedef struct {
    logic [127:0] exp;
    logic [127:0] mask;
    int           id;
  } exp_t;

  exp_t fq[$];
  exp_t sq[$];

  logic [7:0] model [16384];
  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] M8   = 128'hff;
  localparam logic [127:0] M32  = 128'hffff_ffff;
  localparam logic [127:0] M64  = {64'h0, {64{1'b1}}};
  localparam logic [127:0] M88  = {40'h0, {88{1'b1}}};
  localparam logic [127:0] MALL = {128{1'b1}};

  task automatic chk(input bit ok, input string name,
                     input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [127:0] mwin(input logic [31:0] a);
    logic [127:0] r;
    logic [13:0]  idx;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      idx = 14'(a + 32'(i));
      r[8*i +: 8] = model[idx];
    end
    return r;
  endfunction

  task automatic mwrite(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int n;
    logic [13:0] idx;
    n = (sz > 3'd4) ? 4 : int'(sz);
    for (int k = 0; k < n; k++) begin
      idx = 14'(a + 32'(k));
      model[idx] = d[8*k +: 8];
    end
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    bus_tcm_stbuf_write_addr = a;
    bus_tcm_stbuf_write_size = sz;
    bus_tcm_stbuf_data       = d;
    bus_tcm_stbuf_wr         = 1'b1;
    mwrite(a, sz, d);
  endtask

  task automatic set_f(input logic [31:0] a, input logic [127:0] m,
                       input logic [127:0] e, input int id);
    exp_t x;
    bus_tcm_fetch_addr = a;
    bus_tcm_fetch_rd   = 1'b1;
    x.exp = e; x.mask = m; x.id = id;
    fq.push_back(x);
  endtask

  task automatic set_s(input logic [31:0] a, input logic [127:0] m,
                       input logic [127:0] e, input int id);
    exp_t x;
    bus_tcm_stbuf_read_addr = a;
    bus_tcm_stbuf_read_size = 3'($urandom_range(0, 7));
    bus_tcm_stbuf_rd        = 1'b1;
    x.exp = e; x.mask = m; x.id = id;
    sq.push_back(x);
  endtask

  task automatic set_fm(input logic [31:0] a, input int id);
    set_f(a, MALL, mwin(a), id);
  endtask

  task automatic set_sm(input logic [31:0] a, input int id);
    set_s(a, MALL, mwin(a), id);
  endtask

  task automatic tick();
    @(negedge clk);
    bus_tcm_fetch_rd = 1'b0;
    bus_tcm_stbuf_rd = 1'b0;
    bus_tcm_stbuf_wr = 1'b0;
  endtask

  // Monitor: a read sampled at a posedge is checked just after that edge.
  logic mon_f, mon_s;
  always @(posedge clk) begin
    exp_t e;
    mon_f = bus_tcm_fetch_rd & rst;
    mon_s = bus_tcm_stbuf_rd & rst;
    #1;
    if (mon_f) begin
      if (fq.size() == 0) begin
        chk(1'b0, "fetch_underflow", tcm_bus_fetch_data, '0);
      end else begin
        e = fq.pop_front();
        chk(((tcm_bus_fetch_data ^ e.exp) & e.mask) == '0,
            $sformatf("fetch#%0d", e.id), tcm_bus_fetch_data & e.mask, e.exp & e.mask);
      end
    end
    if (mon_s) begin
      if (sq.size() == 0) begin
        chk(1'b0, "stbuf_underflow", tcm_bus_stbuf_data, '0);
      end else begin
        e = sq.pop_front();
        chk(((tcm_bus_stbuf_data ^ e.exp) & e.mask) == '0,
            $sformatf("stbuf#%0d", e.id), tcm_bus_stbuf_data & e.mask, e.exp & e.mask);
      end
    end
  end

  initial begin
    logic [31:0] a, d, prev_a, w0, w1;
    logic [2:0]  sz;

    rst = 1'b0;
    bus_tcm_fetch_addr = '0; bus_tcm_fetch_rd = 1'b0;
    bus_tcm_stbuf_read_addr = '0; bus_tcm_stbuf_read_size = '0; bus_tcm_stbuf_rd = 1'b0;
    bus_tcm_stbuf_write_addr = '0; bus_tcm_stbuf_write_size = '0;
    bus_tcm_stbuf_data = '0; bus_tcm_stbuf_wr = 1'b0;
    for (int i = 0; i < 16384; i++) model[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk(tcm_bus_fetch_data == '0, "reset_fetch", tcm_bus_fetch_data, '0);
    chk(tcm_bus_stbuf_data == '0, "reset_stbuf", tcm_bus_stbuf_data, '0);
    rst = 1'b1;
    tick();

    // Byte write / read
    set_wr(32'h0, 3'd1, 32'ha5a5a5a5); tick();
    set_s(32'h0, M8, 128'ha5, 1); tick();

    // Word and unaligned reads
    set_wr(32'h0, 3'd4, 32'h12345678); tick();
    set_wr(32'h4, 3'd4, 32'h90abcdef); tick();
    set_f(32'h0, M32, 128'h12345678, 2); set_s(32'h0, M32, 128'h12345678, 3); tick();
    set_s(32'h4, M32, 128'h90abcdef, 4); tick();
    set_f(32'h3, M32, 128'habcdef12, 5); tick();
    tick(); tick();
    chk(tcm_bus_fetch_data[31:0] == 32'habcdef12, "hold_fetch",
        {96'h0, tcm_bus_fetch_data[31:0]}, 128'habcdef12);
    chk(tcm_bus_stbuf_data[31:0] == 32'h90abcdef, "hold_stbuf",
        {96'h0, tcm_bus_stbuf_data[31:0]}, 128'h90abcdef);

    // Mixed-size unaligned writes, some crossing a 16-byte line
    set_wr(32'h8,  3'd2, 32'h0000a55a); tick();
    set_wr(32'ha,  3'd1, 32'h000000cc); tick();
    set_wr(32'hb,  3'd4, 32'ha5cbeeac); tick();
    set_wr(32'hf,  3'd1, 32'h000000cb); tick();
    set_wr(32'h10, 3'd4, 32'haabbccdd); tick();
    set_f(32'h0, MALL, 128'hcba5cbee_accca55a_90abcdef_12345678, 6);
    set_s(32'h5, M88,  128'hcba5cbee_accca55a_90abcd, 7); tick();
    set_f(32'hc, M64,  128'haabbccdd_cba5cbee, 8);
    set_s(32'h0, MALL, 128'hcba5cbee_accca55a_90abcdef_12345678, 9); tick();

    // Size 0 writes nothing; size 7 writes four bytes only
    set_wr(32'h20, 3'd4, 32'h11223344); tick();
    set_wr(32'h28, 3'd4, 32'h55667788); tick();
    set_wr(32'h20, 3'd0, 32'hffffffff); tick();
    set_wr(32'h24, 3'd7, 32'hdeadbeef); tick();
    set_f(32'h20, M32, 128'h11223344, 10);
    set_s(32'h24, M64, 128'h55667788_deadbeef, 11); tick();

    // Upper address bits ignored, line-crossing write, wrap at top of array
    set_wr(32'h4000_003e, 3'd4, 32'hcafef00d); tick();
    set_wr(32'h0000_3ffe, 3'd4, 32'h0badc0de); tick();
    set_f(32'h8000_003e, M32, 128'hcafef00d, 12);
    set_s(32'h0000_3ffe, M32, 128'h0badc0de, 13); tick();
    set_f(32'h0, M32, 128'h12340bad, 14); tick();

    // Same-edge write and read at the same address: new data on both ports
    set_wr(32'h50, 3'd4, 32'h13579bdf);
    set_f(32'h50, M32, 128'h13579bdf, 15);
    set_s(32'h4f, M32 << 8, 128'h13579bdf << 8, 16); tick();

    // Sequential fill of the whole array
    for (int i = 0; i < 4096; i++) begin
      set_wr(32'(4*i), 3'd4, 32'(i)); tick();
    end
    for (int i = 0; i < 4096; i++) begin
      set_f(32'(4*i), M32, 128'(i), 100);
      set_s(32'(4*i), M32, 128'(i), 101); tick();
    end
    for (int i = 0; i < 4096; i++) begin
      set_wr(32'(4*i), 3'd4, 32'(i + 65536)); tick();
    end
    for (int i = 0; i < 4095; i++) begin
      w0 = 32'(i + 65536);
      w1 = 32'(i + 1 + 65536);
      set_f(32'(4*i + 2), M32, 128'((w0 >> 16) | (w1 << 16)), 102);
      set_s(32'(4*i + 2), M32, 128'((w0 >> 16) | (w1 << 16)), 103); tick();
    end

    // Random writes with concurrent reads, including same-address collisions
    prev_a = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      a  = $urandom;
      sz = 3'($urandom_range(0, 7));
      d  = $urandom;
      set_wr(a, sz, d);
      set_fm(prev_a, 200);
      set_sm(a, 201); tick();
      prev_a = a;
    end
    for (int n = 0; n < 500; n++) begin
      a  = $urandom;
      d  = $urandom;
      set_wr(a, 3'd4, d); tick();
      set_fm(a, 202);
      set_sm(a - 32'($urandom_range(0, 12)), 203); tick();
    end

    // Reset mid-run: outputs clear at once, memory survives
    set_fm(32'h100, 300); set_sm(32'h3ff8, 301); tick();
    #2 rst = 1'b0;
    #1;
    chk(tcm_bus_fetch_data == '0, "midreset_fetch", tcm_bus_fetch_data, '0);
    chk(tcm_bus_stbuf_data == '0, "midreset_stbuf", tcm_bus_stbuf_data, '0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    set_fm(32'h100, 302); set_sm(32'h3ff8, 303); tick();
    tick();

    for (int k = 0; k < 10 && (fq.size() != 0 || sq.size() != 0); k++) tick();
    if (fq.size() != 0 || sq.size() != 0) begin
      chk(1'b0, "drain", 128'(fq.size() + sq.size()), '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
